// File: rtl/mem_cmd_scheduler_if.sv
// Command channel of the memory command scheduler: valid/ready handshake
// carrying an opcode, target bank address, row and start column.
interface mem_cmd_scheduler_if #(
  parameter int BGWIDTH  = 2,
  parameter int BAWIDTH  = 2,
  parameter int COLWIDTH = 10,
  parameter int CHWIDTH  = 5
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [BGWIDTH-1:0]  cmd_bg;
  logic [BAWIDTH-1:0]  cmd_ba;
  logic [CHWIDTH-1:0]  cmd_row;
  logic [COLWIDTH-1:0] cmd_col;

  modport master (
    output cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col,
    output cmd_ready
  );
endinterface

// File: rtl/mem_cmd_scheduler.sv
// Per-bank ACT/PRE state machines with tRCD/tRP timers plus one shared
// RD/WR burst engine (tCL wait, then BL wrapping beats).
module mem_cmd_scheduler #(
  parameter int BGWIDTH       = 2,
  parameter int BAWIDTH       = 2,
  parameter int COLWIDTH      = 10,
  parameter int CHWIDTH       = 5,
  parameter int BLWIDTH       = 3,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  parameter int TCL           = 4,
  parameter int BANKGROUPS    = 2**BGWIDTH,
  parameter int BANKSPERGROUP = 2**BAWIDTH
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  mem_cmd_scheduler_if.slave                                     cmd_if,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]               rd_o_wr_o,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]  row_o,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][COLWIDTH-1:0] column_o,
  output logic                                                   beat_valid_o,
  output logic [BGWIDTH-1:0]                                     beat_bg_o,
  output logic [BAWIDTH-1:0]                                     beat_ba_o,
  output logic                                                   beat_rd_o,
  output logic                                                   cmd_err_o
);

  localparam int BL = 2**BLWIDTH;
  localparam int TW = 8;

  typedef enum logic [1:0] {OP_ACT = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10, OP_PRE = 2'b11} op_e;
  typedef enum logic [1:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING} bank_state_e;
  typedef enum logic [1:0] {E_IDLE, E_WAIT, E_BURST} eng_state_e;

  bank_state_e bank_q  [BANKGROUPS][BANKSPERGROUP];
  logic [TW-1:0] timer_q [BANKGROUPS][BANKSPERGROUP];

  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]               rd_o_wr_q;
  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]  row_q;
  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][COLWIDTH-1:0] column_q;

  eng_state_e          eng_q;
  logic [TW-1:0]       ecnt_q;
  logic [BGWIDTH-1:0]  tgt_bg_q;
  logic [BAWIDTH-1:0]  tgt_ba_q;
  logic                tgt_rd_q;
  logic [COLWIDTH-1:0] base_col_q;
  logic                beat_valid_q;
  logic [BGWIDTH-1:0]  beat_bg_q;
  logic [BAWIDTH-1:0]  beat_ba_q;
  logic                beat_rd_q;
  logic                cmd_err_q;

  op_e         op;
  bank_state_e tgt_state;
  logic        eng_busy;
  logic        cmd_ready_d;
  logic        cmd_fire;
  logic        cmd_legal;

  // Column of beat k: low BLWIDTH bits wrap inside the burst-aligned block.
  function automatic logic [COLWIDTH-1:0] beat_col(input logic [COLWIDTH-1:0] base,
                                                    input logic [BLWIDTH-1:0]  k);
    logic [BLWIDTH-1:0] low;
    low = base[BLWIDTH-1:0] + k;
    return {base[COLWIDTH-1:BLWIDTH], low};
  endfunction

  assign op = op_e'(cmd_if.cmd_op);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tgt_state   = bank_q[cmd_if.cmd_bg][cmd_if.cmd_ba];
    eng_busy    = (eng_q != E_IDLE);
    cmd_ready_d = 1'b1;
    cmd_legal   = 1'b0;
    if (tgt_state == B_ACTIVATING || tgt_state == B_PRECHARGING) cmd_ready_d = 1'b0;
    if ((op == OP_RD || op == OP_WR) && eng_busy) cmd_ready_d = 1'b0;
    if (op == OP_PRE && eng_busy && cmd_if.cmd_bg == tgt_bg_q && cmd_if.cmd_ba == tgt_ba_q)
      cmd_ready_d = 1'b0;
    if (op == OP_ACT) cmd_legal = (tgt_state == B_IDLE);
    else              cmd_legal = (tgt_state == B_ACTIVE);
    cmd_fire = cmd_if.cmd_valid && cmd_ready_d;
  end

  assign cmd_if.cmd_ready = cmd_ready_d;

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: row/column arrays are reset because their values are visible outputs after reset.
      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          bank_q[g][b]  <= B_IDLE;
          timer_q[g][b] <= '0;
        end
      end
      rd_o_wr_q    <= '0;
      row_q        <= '0;
      column_q     <= '0;
      eng_q        <= E_IDLE;
      ecnt_q       <= '0;
      tgt_bg_q     <= '0;
      tgt_ba_q     <= '0;
      tgt_rd_q     <= 1'b0;
      base_col_q   <= '0;
      beat_valid_q <= 1'b0;
      beat_bg_q    <= '0;
      beat_ba_q    <= '0;
      beat_rd_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      cmd_err_q <= cmd_fire && !cmd_legal;

      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          if (bank_q[g][b] == B_ACTIVATING || bank_q[g][b] == B_PRECHARGING) begin
            if (timer_q[g][b] <= TW'(1)) begin
              bank_q[g][b]  <= (bank_q[g][b] == B_ACTIVATING) ? B_ACTIVE : B_IDLE;
              timer_q[g][b] <= '0;
            end else begin
              timer_q[g][b] <= timer_q[g][b] - TW'(1);
            end
          end
        end
      end

      // Legal commands only ever target IDLE/ACTIVE banks or an idle engine,
      // so they never collide with the timer or engine updates.
      if (cmd_fire && cmd_legal) begin
        unique case (op)
          OP_ACT: begin
            bank_q[cmd_if.cmd_bg][cmd_if.cmd_ba]  <= B_ACTIVATING;
            timer_q[cmd_if.cmd_bg][cmd_if.cmd_ba] <= TW'(TRCD);
            row_q[cmd_if.cmd_bg][cmd_if.cmd_ba]   <= cmd_if.cmd_row;
          end
          OP_PRE: begin
            bank_q[cmd_if.cmd_bg][cmd_if.cmd_ba]  <= B_PRECHARGING;
            timer_q[cmd_if.cmd_bg][cmd_if.cmd_ba] <= TW'(TRP);
          end
          OP_RD, OP_WR: begin
            eng_q      <= E_WAIT;
            ecnt_q     <= TW'(TCL);
            tgt_bg_q   <= cmd_if.cmd_bg;
            tgt_ba_q   <= cmd_if.cmd_ba;
            tgt_rd_q   <= (op == OP_RD);
            base_col_q <= cmd_if.cmd_col;
          end
          default: ;
        endcase
      end

      unique case (eng_q)
        E_WAIT: begin
          if (ecnt_q <= TW'(1)) begin
            eng_q                        <= E_BURST;
            ecnt_q                       <= '0;
            beat_valid_q                 <= 1'b1;
            beat_bg_q                    <= tgt_bg_q;
            beat_ba_q                    <= tgt_ba_q;
            beat_rd_q                    <= tgt_rd_q;
            rd_o_wr_q[tgt_bg_q][tgt_ba_q] <= !tgt_rd_q;
            column_q[tgt_bg_q][tgt_ba_q]  <= beat_col(base_col_q, '0);
          end else begin
            ecnt_q <= ecnt_q - TW'(1);
          end
        end
        E_BURST: begin
          if (ecnt_q == TW'(BL - 1)) begin
            eng_q        <= E_IDLE;
            ecnt_q       <= '0;
            beat_valid_q <= 1'b0;
            beat_bg_q    <= '0;
            beat_ba_q    <= '0;
            beat_rd_q    <= 1'b0;
            rd_o_wr_q    <= '0;
          end else begin
            ecnt_q                       <= ecnt_q + TW'(1);
            column_q[tgt_bg_q][tgt_ba_q] <= beat_col(base_col_q, ecnt_q[BLWIDTH-1:0] + BLWIDTH'(1));
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_o_wr_o    = rd_o_wr_q;
  assign row_o        = row_q;
  assign column_o     = column_q;
  assign beat_valid_o = beat_valid_q;
  assign beat_bg_o    = beat_bg_q;
  assign beat_ba_o    = beat_ba_q;
  assign beat_rd_o    = beat_rd_q;
  assign cmd_err_o    = cmd_err_q;

endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// Directed bench for mem_cmd_scheduler: expected beats are queued at command
// acceptance and checked by a negedge monitor; handshake timing checked inline.
module tb_mem_cmd_scheduler;

  localparam logic [1:0] ACT = 2'b00, RD = 2'b01, WR = 2'b10, PRE = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_cmd_scheduler_if bus ();

  logic [3:0][3:0]       rd_o_wr_o;
  logic [3:0][3:0][4:0]  row_o;
  logic [3:0][3:0][9:0]  column_o;
  logic                  beat_valid_o;
  logic [1:0]            beat_bg_o;
  logic [1:0]            beat_ba_o;
  logic                  beat_rd_o;
  logic                  cmd_err_o;

  mem_cmd_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_if       (bus),
    .rd_o_wr_o    (rd_o_wr_o),
    .row_o        (row_o),
    .column_o     (column_o),
    .beat_valid_o (beat_valid_o),
    .beat_bg_o    (beat_bg_o),
    .beat_ba_o    (beat_ba_o),
    .beat_rd_o    (beat_rd_o),
    .cmd_err_o    (cmd_err_o)
  );

  typedef struct {
    logic [1:0] bg;
    logic [1:0] ba;
    logic       rd;
    logic [9:0] col;
    int         cyc;
  } beat_t;

  beat_t sb[$];
  int n_assert   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int beats_seen = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Beat monitor: every beat must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    logic [3:0][3:0] exp_rw;
    if (rst_n) begin
      if (beat_valid_o) begin
        if (sb.size() == 0) begin
          check("beat_unexpected", beat_valid_o, 1'b0);
        end else begin
          e = sb.pop_front();
          exp_rw = '0;
          if (!e.rd) exp_rw[e.bg][e.ba] = 1'b1;
          check("beat_cycle", cyc, e.cyc);
          check("beat_bg", beat_bg_o, e.bg);
          check("beat_ba", beat_ba_o, e.ba);
          check("beat_rd", beat_rd_o, e.rd);
          check("beat_column", column_o[e.bg][e.ba], e.col);
          check("beat_rd_o_wr", rd_o_wr_o, exp_rw);
          beats_seen++;
        end
      end else begin
        check("idle_rd_o_wr", rd_o_wr_o, 16'h0);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] bg, input logic [1:0] ba,
                       input logic [4:0] row, input logic [9:0] col,
                       output int stalls, output int acc_cyc);
    stalls  = 0;
    acc_cyc = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_bg    = bg;
    bus.cmd_ba    = ba;
    bus.cmd_row   = row;
    bus.cmd_col   = col;
    #1;
    while (!bus.cmd_ready && stalls < 60) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!bus.cmd_ready) begin
      check("issue_timeout", stalls, 0);
      bus.cmd_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_burst(input logic [1:0] bg, input logic [1:0] ba, input logic rd,
                            input logic [9:0] col, input int acc_cyc);
    beat_t e;
    for (int k = 0; k < 8; k++) begin
      e.bg  = bg;
      e.ba  = ba;
      e.rd  = rd;
      e.col = {col[9:3], 3'(col[2:0] + 3'(k))};
      e.cyc = acc_cyc + 5 + k;
      sb.push_back(e);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || beat_valid_o); i++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    wait_cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a, b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ACT;
    bus.cmd_bg    = '0;
    bus.cmd_ba    = '0;
    bus.cmd_row   = '0;
    bus.cmd_col   = '0;

    // Reset state
    #12;
    check("rst_beat_valid", beat_valid_o, 1'b0);
    check("rst_cmd_err", cmd_err_o, 1'b0);
    check("rst_rd_o_wr", rd_o_wr_o, 16'h0);
    check("rst_row_zero", logic'(row_o == '0), 1'b1);
    check("rst_column_zero", logic'(column_o == '0), 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);

    // ACT then RD to the same bank: held off for tRCD
    issue(ACT, 2'd1, 2'd2, 5'd5, 10'h0, s, a);
    check("act_stall", s, 0);
    check("act_no_err", cmd_err_o, 1'b0);
    check("row_1_2_act", row_o[1][2], 5'd5);
    issue(RD, 2'd1, 2'd2, 5'd0, 10'h00D, s, a);
    check("rd_holdoff", s, 4);
    push_burst(2'd1, 2'd2, 1'b1, 10'h00D, a);
    drain();
    check("col_1_2_hold", column_o[1][2], 10'h00C);

    // WR during a concurrent ACT/PRE on another bank, then back-to-back RD
    issue(ACT, 2'd0, 2'd0, 5'd1, 10'h0, s, a);
    wait_cycles(4);
    issue(WR, 2'd0, 2'd0, 5'd0, 10'h000, s, a);
    check("wr_no_stall", s, 0);
    push_burst(2'd0, 2'd0, 1'b0, 10'h000, a);
    issue(ACT, 2'd3, 2'd3, 5'h1F, 10'h0, s, a);
    check("act_during_wait", s, 0);
    issue(PRE, 2'd3, 2'd3, 5'd0, 10'h0, s, a);
    check("pre_after_trcd", s, 4);
    check("row_3_3", row_o[3][3], 5'h1F);
    issue(RD, 2'd1, 2'd2, 5'd0, 10'h3F7, s, a);
    check("rd_bubble", s, 6);
    push_burst(2'd1, 2'd2, 1'b1, 10'h3F7, a);
    drain();
    check("col_0_0_last", column_o[0][0], 10'h007);
    check("col_1_2_wrap", column_o[1][2], 10'h3F6);

    // Illegal commands
    issue(RD, 2'd2, 2'd1, 5'd0, 10'h010, s, a);
    check("rd_idle_err", cmd_err_o, 1'b1);
    wait_cycles(1);
    check("rd_idle_err_pulse", cmd_err_o, 1'b0);
    issue(ACT, 2'd1, 2'd2, 5'd9, 10'h0, s, a);
    check("act_active_err", cmd_err_o, 1'b1);
    check("act_active_row", row_o[1][2], 5'd5);
    wait_cycles(10);

    // PRE to the burst target stalls until the burst ends
    issue(RD, 2'd1, 2'd2, 5'd0, 10'h100, s, a);
    push_burst(2'd1, 2'd2, 1'b1, 10'h100, a);
    issue(PRE, 2'd1, 2'd2, 5'd0, 10'h0, s, a);
    check("pre_target_stall", s, 12);
    check("pre_target_err", cmd_err_o, 1'b0);
    issue(ACT, 2'd1, 2'd2, 5'd3, 10'h0, s, a);
    check("act_after_trp", s, 4);
    check("act_after_trp_err", cmd_err_o, 1'b0);
    check("row_1_2_new", row_o[1][2], 5'd3);
    check("queue_empty", sb.size(), 0);

    // Reset in the middle of a write burst
    issue(ACT, 2'd2, 2'd2, 5'd7, 10'h0, s, a);
    wait_cycles(4);
    b0 = beats_seen;
    issue(WR, 2'd2, 2'd2, 5'd0, 10'h004, s, a);
    push_burst(2'd2, 2'd2, 1'b0, 10'h004, a);
    for (int i = 0; i < 40 && beats_seen < b0 + 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("beat3_reached", beats_seen, b0 + 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_beat_valid", beat_valid_o, 1'b0);
    check("mid_rst_rd_o_wr", rd_o_wr_o, 16'h0);
    check("mid_rst_row_zero", logic'(row_o == '0), 1'b1);
    check("mid_rst_column_zero", logic'(column_o == '0), 1'b1);
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(12);
    issue(ACT, 2'd2, 2'd2, 5'd2, 10'h0, s, a);
    check("post_rst_act_stall", s, 0);
    check("post_rst_act_err", cmd_err_o, 1'b0);
    issue(ACT, 2'd1, 2'd2, 5'd4, 10'h0, s, a);
    check("post_rst_act2_err", cmd_err_o, 1'b0);
    wait_cycles(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_cmd_scheduler.md
MEM_CMD_SCHEDULER -- requirements
Module: mem_cmd_scheduler

Interface
REQ-001 Params: BGWIDTH=2, bank-group address bits; BAWIDTH=2, bank address bits; COLWIDTH=10, column bits; CHWIDTH=5, row bits; BLWIDTH=3, log2 burst length (BL=8); TRCD=4, ACT-to-RD/WR cycles; TRP=4, PRE-to-ACT cycles; TCL=4, RD/WR-to-first-beat cycles; BANKGROUPS=2**BGWIDTH; BANKSPERGROUP=2**BAWIDTH.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  command accepted on cycles where cmd_valid && cmd_ready.
REQ-006 cmd_op  in  2  00=ACT, 01=RD, 10=WR, 11=PRE.
REQ-007 cmd_bg  in  BGWIDTH  target bank group; cmd_ba in BAWIDTH target bank.
REQ-008 cmd_row  in  CHWIDTH  row for ACT; cmd_col in COLWIDTH start column for RD/WR.
REQ-009 rd_o_wr  out  1 per [BANKGROUPS][BANKSPERGROUP]  1=write beat this cycle, else 0.
REQ-010 row  out  CHWIDTH per [BANKGROUPS][BANKSPERGROUP]  open row of each bank.
REQ-011 column  out  COLWIDTH per [BANKGROUPS][BANKSPERGROUP]  current beat column.
REQ-012 beat_valid out 1 data beat on selected bank; beat_bg/beat_ba out BGWIDTH/BAWIDTH bank of beat; beat_rd out 1 beat is read.
REQ-013 cmd_err  out  1  one-cycle pulse, accepted command was illegal.

Function
REQ-014 Each bank SHALL hold an FSM: IDLE, ACTIVATING, ACTIVE, PRECHARGING, plus a timer.
REQ-015 Accepted ACT to IDLE bank: latch cmd_row into row[bg][ba], go ACTIVATING, timer=TRCD; ACTIVE after TRCD cycles.
REQ-016 Accepted PRE to ACTIVE bank: go PRECHARGING, timer=TRP; IDLE after TRP cycles; row output retained.
REQ-017 Accepted RD/WR to ACTIVE bank starts the single shared burst engine: WAIT (TCL cycles) then BURST (BL beats).
REQ-018 During BURST, beat_valid=1, beat_bg/ba=target, beat_rd=1 for RD; rd_o_wr[target]=1 only for WR beats.
REQ-019 Beat k column = {cmd_col[COLWIDTH-1:BLWIDTH], (cmd_col[BLWIDTH-1:0]+k) mod BL}; wraps within burst-aligned block, upper bits never change.
REQ-020 column[bg][ba] of non-target banks SHALL hold last value; rd_o_wr of non-target banks SHALL be 0.
REQ-021 cmd_ready=0 when: target bank ACTIVATING or PRECHARGING; or op is RD/WR and burst engine not idle; or op is PRE and target bank is the current burst target.
REQ-022 ACT/PRE to other banks SHALL be accepted during WAIT/BURST; per-bank timers run concurrently.
REQ-023 Illegal accepted commands (ACT to ACTIVE, RD/WR/PRE to IDLE): cmd_err=1 next cycle, no state change.
REQ-024 Last burst beat and new RD/WR in same cycle: cmd_ready=0 that cycle; engine idle next cycle, accepted then (one bubble minimum).
REQ-025 cmd_ready is combinational from cmd_* and registered state; all other outputs registered.

Reset
REQ-026 rst_n low SHALL immediately set all banks IDLE, timers 0, burst engine idle, row/column all 0, rd_o_wr all 0, beat_valid 0, beat_rd 0, beat_bg/ba 0, cmd_err 0.
REQ-027 Reset mid-burst or mid-timer SHALL abort without completing beats; cmd_ready=1 for legal ACT after release.

Verification
REQ-028 ACT bg1 ba2 row 5 -> row[1][2]=5; RD to that bank held off 4 cycles (cmd_ready=0), accepted cycle 5.
REQ-029 RD bg1 ba2 col 0x0D -> after 4 cycles, 8 beats, columns 0x0D,0x0E,0x0F,0x08..0x0C, beat_rd=1, rd_o_wr[1][2]=0.
REQ-030 WR bg0 ba0 col 0 during bg3 ba3 ACT -> both proceed; rd_o_wr[0][0]=1 exactly 8 cycles; bg3 ba3 ACTIVE after 4.
REQ-031 RD to IDLE bank -> cmd_err pulse 1 cycle, no beats; ACT to ACTIVE bank -> cmd_err, row unchanged.
REQ-032 PRE to burst target mid-burst -> stalled until burst ends; then IDLE after 4 cycles, ACT accepted.
REQ-033 rst_n low at beat 3 -> beat_valid and rd_o_wr 0 immediately, all banks IDLE, no further beats.
